average_read_control: RTL

Read-side sequencer for the 16-lane average-pooling buffer. On a start pulse it walks the buffer in the same lane grouping the write path uses: opcodes 32–37, three lanes per group, with lane 15 alone in the last group. It accumulates the 16 signed lane values and returns their mean through a valid/ready handshake. It sits between the pooling buffer's read port and the downstream activation/requantisation stage.

---
 rtl/average_read_control.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/average_read_control.sv
// average_read_control
// Read-side sequencer for the 16-lane average-pooling buffer. A start pulse
// walks the buffer in write-path lane groups (opcodes 32..37, three lanes per
// group, lane 15 alone in group 5). It accumulates the 16 signed lanes and
// returns their floor mean over a valid/ready handshake.
//
// Handshake: o_avg is transferred on a rising edge where o_avgValid and
// i_avgReady are both high. While o_avgValid is high, o_avg does not change.
// o_avgValid stays high until that transfer happens.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         request pulse, sampled only in IDLE
//   o_busy          high in every state except IDLE
//   o_rdOpcode      group opcode being read (32..37), 0 when no read
//   o_selRead       lane read mask for the current group, 0 when no read
//   i_rdData        three lane slots, returned one cycle after the select
//   o_avg           signed mean of the 16 lanes (sum >>> 4)
//   o_avgValid      o_avg valid, held until accepted
//   i_avgReady      downstream accept
//   o_dbg_state     current FSM state (IDLE=0, ISSUE=1, DRAIN=2, OUT=3)
module average_read_control #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic [5:0]            o_rdOpcode,
  output logic [15:0]           o_selRead,
  input  logic [3*DATA_W-1:0]   i_rdData,
  output logic [DATA_W-1:0]     o_avg,
  output logic                  o_avgValid,
  input  logic                  i_avgReady,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               g_q, g_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pend_q, pend_d;    // a select was issued last cycle
  logic                     plast_q, plast_d;  // ...and it was group 5
  logic                     busy_q, busy_d;
  logic [5:0]               opcode_q, opcode_d;
  logic [15:0]              sel_q, sel_d;
  logic [DATA_W-1:0]        avg_q, avg_d;
  logic                     valid_q, valid_d;

  logic signed [DATA_W-1:0] s0, s1, s2;
  logic signed [ACC_W-1:0]  grp_sum, sum_next, sum_shift;
  logic [2:0]               g_next;

  function automatic logic [15:0] group_mask(input logic [2:0] g);
    case (g)
      3'd0:    group_mask = 16'h0007;
      3'd1:    group_mask = 16'h0038;
      3'd2:    group_mask = 16'h01C0;
      3'd3:    group_mask = 16'h0E00;
      3'd4:    group_mask = 16'h7000;
      3'd5:    group_mask = 16'h8000;
      default: group_mask = 16'h0000;
    endcase
  endfunction

  always_comb begin
    s0 = i_rdData[0*DATA_W +: DATA_W];
    s1 = i_rdData[1*DATA_W +: DATA_W];
    s2 = i_rdData[2*DATA_W +: DATA_W];

    // Group 5 carries only lane 15; its upper slots are undefined.
    if (plast_q) grp_sum = ACC_W'(s0);
    else         grp_sum = ACC_W'(s0) + ACC_W'(s1) + ACC_W'(s2);

    // Data is on i_rdData exactly one cycle after its select, so the add is
    // qualified by the registered "select issued" flag rather than the state.
    sum_next  = pend_q ? (acc_q + grp_sum) : acc_q;
    sum_shift = sum_next >>> 4;
    g_next    = g_q + 3'd1;

    state_d  = state_q;
    g_d      = g_q;
    acc_d    = sum_next;
    pend_d   = (state_q == S_ISSUE);
    plast_d  = (state_q == S_ISSUE) && (g_q == 3'd5);
    busy_d   = busy_q;
    opcode_d = opcode_q;
    sel_d    = sel_q;
    avg_d    = avg_q;
    valid_d  = valid_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_ISSUE;
          g_d      = 3'd0;
          acc_d    = '0;
          busy_d   = 1'b1;
          opcode_d = 6'd32;
          sel_d    = group_mask(3'd0);
        end
      end
      S_ISSUE: begin
        if (g_q == 3'd5) begin
          state_d  = S_DRAIN;
          g_d      = 3'd0;
          opcode_d = 6'd0;
          sel_d    = 16'h0000;
        end else begin
          g_d      = g_next;
          opcode_d = 6'd32 + {3'b000, g_next};
          sel_d    = group_mask(g_next);
        end
      end
      S_DRAIN: begin
        // sum_next already includes group 5; the sum of 16 DATA_W values
        // divided by 16 always fits back into DATA_W.
        state_d = S_OUT;
        avg_d   = sum_shift[DATA_W-1:0];
        valid_d = 1'b1;
      end
      S_OUT: begin
        if (i_avgReady) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      g_q      <= 3'd0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      plast_q  <= 1'b0;
      busy_q   <= 1'b0;
      opcode_q <= 6'd0;
      sel_q    <= 16'h0000;
      avg_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      plast_q  <= plast_d;
      busy_q   <= busy_d;
      opcode_q <= opcode_d;
      sel_q    <= sel_d;
      avg_q    <= avg_d;
      valid_q  <= valid_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_rdOpcode  = opcode_q;
  assign o_selRead   = sel_q;
  assign o_avg       = avg_q;
  assign o_avgValid  = valid_q;
  assign o_dbg_state = state_q;

endmodule
